// File: rtl/rx_frame_pkg.sv
// Shared definitions for the serial command-frame decoder: FSM encoding,
// frame constants and the checksum rule.
package rx_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GET_CODE = 2'd1,
    ST_GET_ARG  = 2'd2,
    ST_GET_CHK  = 2'd3
  } rx_state_e;

  localparam logic [7:0] SOF_DEFAULT = 8'hAA;
  localparam int unsigned FRAME_LEN  = 4;

  // Wide enough for the largest legal timeout (2^20-1).
  localparam int unsigned TO_CNT_W = 20;

  function automatic logic [7:0] frame_chk(input logic [7:0] code, input logic [7:0] arg);
    return code ^ arg;
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags the cycle on
// which the TIMEOUT_CYCLES-th consecutive idle cycle completes.
module byte_timeout
  import rx_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic reload,
  output logic expire
);

  localparam logic [TO_CNT_W-1:0] LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_W-1:0] cnt_q, cnt_d;

  // A reload on the final cycle suppresses expiry: the arriving byte wins.
  assign expire = enable && !reload && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (reload || !enable || expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_frame_decoder.sv
// Decodes 4-byte frames (SOF, code, arg, code^arg) from a UART byte stream into
// registered command strobes, with inter-byte timeout and saturating error count.
//
// Handshake: RxD_data_ready is a one-cycle strobe qualifying RxD_data; there is
// no back-pressure, every strobe is consumed on the cycle it is seen.
module rx_frame_decoder
  import rx_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  SOF            = SOF_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD_data_ready,
  input  logic [7:0] RxD_data,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       busy,
  output rx_state_e  dbg_state
);

  rx_state_e  state_q, state_d;
  logic [7:0] code_q, code_d;
  logic [7:0] arg_q, arg_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] cmd_code_q, cmd_code_d;
  logic [7:0] cmd_arg_q, cmd_arg_d;
  logic [7:0] err_count_q, err_count_d;
  logic       to_expire;

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .enable(state_q != ST_IDLE),
    .reload(RxD_data_ready),
    .expire(to_expire)
  );

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    arg_d       = arg_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    cmd_arg_d   = cmd_arg_q;
    err_count_d = err_count_q;

    if (RxD_data_ready) begin
      unique case (state_q)
        ST_IDLE: begin
          if (RxD_data == SOF) begin
            state_d = ST_GET_CODE;
          end
        end
        ST_GET_CODE: begin
          code_d  = RxD_data;
          state_d = ST_GET_ARG;
        end
        ST_GET_ARG: begin
          arg_d   = RxD_data;
          state_d = ST_GET_CHK;
        end
        ST_GET_CHK: begin
          state_d = ST_IDLE;
          if (RxD_data == frame_chk(code_q, arg_q)) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = code_q;
            cmd_arg_d   = arg_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (to_expire) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end

    if (frame_err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      arg_q       <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      cmd_code_q  <= '0;
      cmd_arg_q   <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      arg_q       <= arg_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      cmd_code_q  <= cmd_code_d;
      cmd_arg_q   <= cmd_arg_d;
      err_count_q <= err_count_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_arg   = cmd_arg_q;
  assign err_count = err_count_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/rx_frame_decoder.md
RX_FRAME_DECODER -- requirements
Module: rx_frame_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000: inter-byte timeout in clk cycles; legal range 2 to 2^20-1.
REQ-002 Parameter SOF, default 8'hAA: start-of-frame byte value.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 RxD_data_ready  input  1  one-cycle strobe from the UART receiver; RxD_data is valid on the same cycle.
REQ-006 RxD_data  input  8  received byte.
REQ-007 cmd_valid  output  1  one-cycle strobe; frame accepted.
REQ-008 cmd_code  output  8  command byte of the accepted frame; held until the next accepted frame.
REQ-009 cmd_arg  output  8  argument byte of the accepted frame; held until the next accepted frame.
REQ-010 frame_err  output  1  one-cycle strobe; frame discarded.
REQ-011 err_count  output  8  saturating count of discarded frames.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 Frame format SHALL be four bytes: SOF, code, arg, chk, where chk = code XOR arg.
REQ-014 The FSM SHALL have the states IDLE, GET_CODE, GET_ARG, GET_CHK.
REQ-015 IDLE SHALL go to GET_CODE on a strobe carrying SOF; any non-SOF byte in IDLE SHALL be dropped silently, with no error.
REQ-016 GET_CODE SHALL latch the byte and go to GET_ARG, and GET_ARG SHALL latch the byte and go to GET_CHK, on each strobe; SOF values in these states SHALL be treated as data.
REQ-017 On a strobe in GET_CHK, a matching chk SHALL cause the code and arg to be copied to cmd_code/cmd_arg and cmd_valid to pulse; a mismatch SHALL cause frame_err to pulse; both outcomes SHALL return the FSM to IDLE.
REQ-018 Latency: cmd_valid or frame_err SHALL assert exactly one cycle after the chk-byte strobe, for exactly one cycle.
REQ-019 cmd_code/cmd_arg SHALL update on the same cycle cmd_valid rises; they SHALL never change on a rejected frame.
REQ-020 The timeout counter SHALL reload on every strobe and count while busy; when it reaches TIMEOUT_CYCLES with no strobe, frame_err SHALL pulse and the FSM SHALL return to IDLE.
REQ-021 If a strobe coincides with the timeout cycle, the strobe SHALL win: the byte is consumed, the counter reloads, and no error is raised.
REQ-022 The timeout counter SHALL be inert in IDLE.
REQ-023 err_count SHALL increment by 1 on every frame_err pulse and saturate at 8'hFF.
REQ-024 cmd_valid and frame_err SHALL never be high on the same cycle.
REQ-025 A strobe arriving on the same cycle as cmd_valid/frame_err SHALL be processed normally from IDLE.

Reset
REQ-026 While rst is high, the state SHALL be IDLE, all outputs 0, and the timeout counter 0.
REQ-027 rst asserted mid-frame SHALL discard the partial frame without a frame_err pulse or an err_count change.
REQ-028 The first strobe SHALL be honoured on the cycle after rst deasserts.

Structure
REQ-029 A shared package rx_frame_pkg SHALL hold the FSM state encoding, the default SOF constant, and the frame length constant (4).
REQ-030 The timeout counter SHALL be a sub-module byte_timeout with ports clk, rst, enable, reload, and expire.
REQ-031 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Verification
REQ-032 Scenario: bytes AA,03,05,06 → one cmd_valid pulse one cycle after the 06 strobe; cmd_code=03, cmd_arg=05; err_count=0.
REQ-033 Scenario: bytes AA,03,05,07 → frame_err pulse; err_count=1; cmd_code/cmd_arg unchanged.
REQ-034 Scenario: bytes 11,22,AA,AA,01,AB → 11 and 22 dropped; one accepted frame with code=AA, arg=01.
REQ-035 Scenario: TIMEOUT_CYCLES=10; AA,03, then no strobe for 10 cycles → frame_err pulse, FSM in IDLE; a strobe landing on exactly cycle 10 → no error.
REQ-036 Scenario: 300 bad-checksum frames → err_count=FF and holding.
REQ-037 Scenario: rst pulsed after AA,03, then AA,01,02,03 → no frame_err; one cmd_valid with code=01, arg=02.
